// File: rtl/reg_file_sb.sv
// Integer register file with two combinational read ports, one write-back port
// and a scoreboard that marks destinations pending between issue and write-back.
module reg_file_sb #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int AW       = 5,
    parameter bit BYPASS   = 1,
    parameter bit ZERO_REG = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AW-1:0]    rs1_enc,
    input  logic [AW-1:0]    rs2_enc,
    output logic [XLEN-1:0]  rs1,
    output logic [XLEN-1:0]  rs2,
    output logic             rs1_busy,
    output logic             rs2_busy,
    output logic             hazard,
    input  logic             write_enable,
    input  logic [AW-1:0]    reg_enc_write,
    input  logic [XLEN-1:0]  reg_w,
    input  logic             update_enable,
    input  logic [AW-1:0]    reg_dest_enc,
    output logic [NREGS-1:0] outdated
);

    localparam int IW = (NREGS > 1) ? $clog2(NREGS) : 1;

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] outdated_q;
    logic [NREGS-1:0] outdated_d;
    logic             wr_ok;
    logic             dest_ok;

    function automatic logic in_range(input logic [AW-1:0] idx);
        return int'(idx) < NREGS;
    endfunction

    function automatic logic writable(input logic [AW-1:0] idx);
        return in_range(idx) && !(ZERO_REG && idx == '0);
    endfunction

    assign wr_ok   = write_enable && writable(reg_enc_write);
    assign dest_ok = update_enable && writable(reg_dest_enc);

    // A newly issued producer keeps its bit even if an older one retires now.
    always_comb begin
        outdated_d = outdated_q;
        if (wr_ok)
            outdated_d[reg_enc_write[IW-1:0]] = 1'b0;
        if (dest_ok)
            outdated_d[reg_dest_enc[IW-1:0]] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            outdated_q <= '0;
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
        end else begin
            outdated_q <= outdated_d;
            if (wr_ok)
                regs[reg_enc_write[IW-1:0]] <= reg_w;
        end
    end

    function automatic logic bypass_hit(input logic [AW-1:0] idx);
        return BYPASS && wr_ok && idx == reg_enc_write;
    endfunction

    function automatic logic [XLEN-1:0] read_data(input logic [AW-1:0] idx);
        if (!writable(idx))
            return '0;
        if (bypass_hit(idx))
            return reg_w;
        return regs[idx[IW-1:0]];
    endfunction

    function automatic logic read_busy(input logic [AW-1:0] idx);
        if (!in_range(idx) || bypass_hit(idx))
            return 1'b0;
        return outdated_q[idx[IW-1:0]];
    endfunction

    always_comb begin
        rs1      = read_data(rs1_enc);
        rs2      = read_data(rs2_enc);
        rs1_busy = read_busy(rs1_enc);
        rs2_busy = read_busy(rs2_enc);
        hazard   = rs1_busy | rs2_busy;
    end

    assign outdated = outdated_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench: a bypassing 32-entry instance and a non-bypassing 16-entry
// instance share stimulus; each cycle is checked against hand-computed values.
module tb_reg_file_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs1_enc, rs2_enc, reg_enc_write, reg_dest_enc;
    logic [31:0] reg_w;
    logic        write_enable, update_enable;

    logic [31:0] a_rs1, a_rs2, b_rs1, b_rs2;
    logic        a_b1, a_b2, a_hz, b_b1, b_b2, b_hz;
    logic [31:0] a_out;
    logic [15:0] b_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reg_file_sb #(.XLEN(32), .NREGS(32), .AW(5), .BYPASS(1), .ZERO_REG(1)) dut_a (
        .clk(clk), .rst(rst),
        .rs1_enc(rs1_enc), .rs2_enc(rs2_enc),
        .rs1(a_rs1), .rs2(a_rs2),
        .rs1_busy(a_b1), .rs2_busy(a_b2), .hazard(a_hz),
        .write_enable(write_enable), .reg_enc_write(reg_enc_write), .reg_w(reg_w),
        .update_enable(update_enable), .reg_dest_enc(reg_dest_enc),
        .outdated(a_out)
    );

    reg_file_sb #(.XLEN(32), .NREGS(16), .AW(5), .BYPASS(0), .ZERO_REG(1)) dut_b (
        .clk(clk), .rst(rst),
        .rs1_enc(rs1_enc), .rs2_enc(rs2_enc),
        .rs1(b_rs1), .rs2(b_rs2),
        .rs1_busy(b_b1), .rs2_busy(b_b2), .hazard(b_hz),
        .write_enable(write_enable), .reg_enc_write(reg_enc_write), .reg_w(reg_w),
        .update_enable(update_enable), .reg_dest_enc(reg_dest_enc),
        .outdated(b_out)
    );

    // Busy triples are packed as {rs1_busy, rs2_busy, hazard}.
    typedef struct {
        logic        rst;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        ue;
        logic [4:0]  ud;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [31:0] a1;
        logic [31:0] a2;
        logic [2:0]  abz;
        logic [31:0] aout;
        logic [31:0] b1;
        logic [31:0] b2;
        logic [2:0]  bbz;
        logic [15:0] bout;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic we, input logic [4:0] wa,
                         input logic [31:0] wd, input logic ue, input logic [4:0] ud,
                         input logic [4:0] r1, input logic [4:0] r2);
        @(negedge clk);
        rst = r; write_enable = we; reg_enc_write = wa; reg_w = wd;
        update_enable = ue; reg_dest_enc = ud; rs1_enc = r1; rs2_enc = r2;
        #1;
    endtask

    initial begin
        rst = 1'b1; write_enable = 1'b0; update_enable = 1'b0;
        reg_enc_write = '0; reg_dest_enc = '0; reg_w = '0;
        rs1_enc = '0; rs2_enc = '0;
        repeat (2) @(posedge clk);

        //              rst we wa  wd            ue ud  r1  r2   a1            a2            abz     aout           b1            b2            bbz     bout
        vecs.push_back('{0, 0, 0,  32'h0,        0, 0,  5,  7,   32'h0,        32'h0,        3'b000, 32'h0,         32'h0,        32'h0,        3'b000, 16'h0});
        vecs.push_back('{0, 1, 5,  32'hDEADBEEF, 1, 5,  5,  0,   32'hDEADBEEF, 32'h0,        3'b000, 32'h0,         32'h0,        32'h0,        3'b000, 16'h0});
        vecs.push_back('{0, 0, 0,  32'h0,        0, 0,  5,  5,   32'hDEADBEEF, 32'hDEADBEEF, 3'b111, 32'h20,        32'hDEADBEEF, 32'hDEADBEEF, 3'b111, 16'h20});
        vecs.push_back('{1, 1, 6,  32'h11,       1, 6,  5,  6,   32'hDEADBEEF, 32'h11,       3'b101, 32'h20,        32'hDEADBEEF, 32'h0,        3'b101, 16'h20});
        vecs.push_back('{0, 0, 0,  32'h0,        0, 0,  5,  6,   32'h0,        32'h0,        3'b000, 32'h0,         32'h0,        32'h0,        3'b000, 16'h0});
        vecs.push_back('{0, 1, 7,  32'h12345678, 0, 0,  0,  7,   32'h0,        32'h12345678, 3'b000, 32'h0,         32'h0,        32'h0,        3'b000, 16'h0});
        vecs.push_back('{0, 0, 0,  32'h0,        0, 0,  7,  7,   32'h12345678, 32'h12345678, 3'b000, 32'h0,         32'h12345678, 32'h12345678, 3'b000, 16'h0});
        vecs.push_back('{0, 1, 0,  32'hFFFFFFFF, 1, 0,  0,  0,   32'h0,        32'h0,        3'b000, 32'h0,         32'h0,        32'h0,        3'b000, 16'h0});
        vecs.push_back('{0, 0, 0,  32'h0,        0, 0,  0,  0,   32'h0,        32'h0,        3'b000, 32'h0,         32'h0,        32'h0,        3'b000, 16'h0});
        vecs.push_back('{0, 0, 0,  32'h0,        1, 3,  3,  0,   32'h0,        32'h0,        3'b000, 32'h0,         32'h0,        32'h0,        3'b000, 16'h0});
        vecs.push_back('{0, 0, 0,  32'h0,        0, 0,  3,  0,   32'h0,        32'h0,        3'b101, 32'h8,         32'h0,        32'h0,        3'b101, 16'h8});
        vecs.push_back('{0, 1, 3,  32'hA5,       0, 0,  3,  0,   32'hA5,       32'h0,        3'b000, 32'h8,         32'h0,        32'h0,        3'b101, 16'h8});
        vecs.push_back('{0, 0, 0,  32'h0,        0, 0,  3,  3,   32'hA5,       32'hA5,       3'b000, 32'h0,         32'hA5,       32'hA5,       3'b000, 16'h0});
        vecs.push_back('{0, 1, 9,  32'h99,       1, 9,  9,  9,   32'h99,       32'h99,       3'b000, 32'h0,         32'h0,        32'h0,        3'b000, 16'h0});
        vecs.push_back('{0, 0, 0,  32'h0,        0, 0,  9,  0,   32'h99,       32'h0,        3'b101, 32'h200,       32'h99,       32'h0,        3'b101, 16'h200});
        vecs.push_back('{0, 1, 20, 32'hCAFE,     1, 20, 20, 9,   32'hCAFE,     32'h99,       3'b011, 32'h200,       32'h0,        32'h99,       3'b011, 16'h200});
        vecs.push_back('{0, 0, 0,  32'h0,        0, 0,  20, 20,  32'hCAFE,     32'hCAFE,     3'b111, 32'h100200,    32'h0,        32'h0,        3'b000, 16'h200});
        vecs.push_back('{0, 1, 9,  32'h1,        0, 0,  9,  20,  32'h1,        32'hCAFE,     3'b011, 32'h100200,    32'h99,       32'h0,        3'b101, 16'h200});
        vecs.push_back('{0, 0, 0,  32'h0,        0, 0,  9,  20,  32'h1,        32'hCAFE,     3'b011, 32'h100000,    32'h1,        32'h0,        3'b000, 16'h0});

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].we, vecs[i].wa, vecs[i].wd,
                  vecs[i].ue, vecs[i].ud, vecs[i].r1, vecs[i].r2);
            check($sformatf("v%0d a_rs1", i), a_rs1, vecs[i].a1);
            check($sformatf("v%0d a_rs2", i), a_rs2, vecs[i].a2);
            check($sformatf("v%0d a_busy", i), {29'd0, a_b1, a_b2, a_hz}, {29'd0, vecs[i].abz});
            check($sformatf("v%0d a_out", i), a_out, vecs[i].aout);
            check($sformatf("v%0d b_rs1", i), b_rs1, vecs[i].b1);
            check($sformatf("v%0d b_rs2", i), b_rs2, vecs[i].b2);
            check($sformatf("v%0d b_busy", i), {29'd0, b_b1, b_b2, b_hz}, {29'd0, vecs[i].bbz});
            check($sformatf("v%0d b_out", i), {16'd0, b_out}, {16'd0, vecs[i].bout});
        end

        // Reset while two producers are in flight, then a late write-back.
        drive(0, 0, 0, 32'h0, 1, 4, 4, 8);
        drive(0, 0, 0, 32'h0, 1, 8, 4, 8);
        check("mid a_b1", {31'd0, a_b1}, 32'd1);
        check("mid a_b2", {31'd0, a_b2}, 32'd0);
        drive(1, 0, 0, 32'h0, 0, 0, 4, 8);
        check("mid a_out_pre", a_out, 32'h100110);
        check("mid b_out_pre", {16'd0, b_out}, 32'h110);
        drive(0, 1, 4, 32'h44, 0, 0, 4, 8);
        check("post a_out", a_out, 32'h0);
        check("post b_out", {16'd0, b_out}, 32'h0);
        check("post a_hz", {31'd0, a_hz}, 32'd0);
        check("post b_hz", {31'd0, b_hz}, 32'd0);
        check("post a_rs1", a_rs1, 32'h44);
        check("post b_rs1", b_rs1, 32'h0);
        drive(0, 0, 0, 32'h0, 0, 0, 4, 9);
        check("late a_rs1", a_rs1, 32'h44);
        check("late b_rs1", b_rs1, 32'h44);
        check("late a_rs2", a_rs2, 32'h0);
        check("late a_out", a_out, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
Parametrised successor to the integer register file: 2 combinational read ports, 1 write-back port, and an integrated scoreboard.
- Scoreboard tracks "outdated" destination registers between decode/issue and write-back.
- Optional write-to-read bypass; optional hardwired-zero x0.
- Sits between the decode unit (read and issue) and the write-back stage. Drives the hazard/stall inputs of the issue logic.

Parameters:
XLEN, 32, data width of each register
NREGS, 32, number of architectural registers (2..32)
AW, 5, encoding width of register indices; must satisfy 2^AW >= NREGS
BYPASS, 1, 1 = a same-cycle write-back is forwarded to read ports and clears busy
ZERO_REG, 1, 1 = register 0 reads as 0, ignores writes, is never marked outdated

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high
rs1_enc  in  AW  read port 1 index
rs2_enc  in  AW  read port 2 index
rs1  out  XLEN  read port 1 data
rs2  out  XLEN  read port 2 data
rs1_busy  out  1  rs1 source is pending write-back
rs2_busy  out  1  rs2 source is pending write-back
hazard  out  1  rs1_busy OR rs2_busy
write_enable  in  1  write-back valid
reg_enc_write  in  AW  write-back index
reg_w  in  XLEN  write-back data
update_enable  in  1  issue of an instruction with a destination register
reg_dest_enc  in  AW  destination index to mark outdated
outdated  out  NREGS  scoreboard vector, bit i = register i pending

Behaviour:
- Reset
  - On a clk edge with rst=1: all registers and all outdated bits become 0. rst has priority over write_enable and update_enable in that cycle.
  - After reset: rs1=rs2=0, busy=0, hazard=0.
- Write
  - At clk edge: if write_enable, the index is < NREGS, and not (ZERO_REG and index==0), then x[reg_enc_write] <= reg_w.
  - Write latency 1 cycle.
- Reads
  - Combinational, zero latency.
  - Index >= NREGS reads 0.
  - With ZERO_REG, index 0 reads 0.
- Bypass (BYPASS=1)
  - If write_enable, the read index equals reg_enc_write, and the index is writable, the read data is reg_w in the same cycle.
  - With BYPASS=0, reads return the stored value, so new data is visible the cycle after write.
- Scoreboard update at clk edge
  - outdated[reg_enc_write] cleared if write_enable.
  - outdated[reg_dest_enc] set if update_enable.
  - Both on the same index in one cycle: set wins. The retiring older producer does not clear the bit for the newly issued one.
  - Index 0 (when ZERO_REG) and indices >= NREGS are never set and always read 0.
- Busy
  - rsN_busy = outdated[rsN_enc], forced to 0 when BYPASS=1 and the same-cycle write hits rsN_enc.
  - hazard = rs1_busy | rs2_busy, purely combinational.
- Writes without a prior set (e.g. after reset) are legal and just update data.
- Reset asserted mid-pipeline discards all pending outdated bits. Write-backs arriving after reset deassertion write data normally.

Test Plan:
- Reset: preload x5=0xDEADBEEF and outdated[5]=1, pulse rst one cycle → next cycle rs1_enc=5 gives rs1=0, outdated=0, hazard=0.
- Write/read: write x7=0x12345678 (BYPASS=0) → rs2_enc=7 reads old value 0 in the write cycle and 0x12345678 the next cycle. With BYPASS=1 it reads 0x12345678 in the write cycle.
- x0: write_enable, reg_enc_write=0, reg_w=0xFFFFFFFF, update_enable with dest=0 → rs1(0)=0, outdated[0]=0, rs1_busy=0.
- Scoreboard: update_enable dest=3 → outdated=0x8, rs1_enc=3 gives rs1_busy=1, hazard=1. Write-back x3=0xA5 → same cycle rs1_busy=0 (BYPASS=1) and rs1=0xA5; next cycle outdated=0.
- Same-index set/clear: write_enable and update_enable both on index 9 in one cycle → outdated[9]=1 after the edge, x9=new data.
- Parameter sweep NREGS=16, AW=5: write to index 20 ignored, read of 20 returns 0, update of 20 leaves outdated unchanged.
